// File: rtl/bcd_seg_display_pkg.sv
// ---------------------------------------------------------------------------
// bcd_seg_display_pkg
// Shared definitions for the HEX display driver:
//   - active-low seven-segment codes, bit order {g,f,e,d,c,b,a}
//   - bcd_width(): number of BCD digits needed to hold a DATA_W-bit value
//   - FSM state encoding for the sequential converter
// ---------------------------------------------------------------------------
package bcd_seg_display_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SHIFT,
      S_STORE,
      S_DONE
   } state_t;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   localparam logic [6:0] SEG_DIGIT [10] = '{
      7'b1000000,   // 0
      7'b1111001,   // 1
      7'b0100100,   // 2
      7'b0110000,   // 3
      7'b0011001,   // 4
      7'b0010010,   // 5
      7'b0000010,   // 6
      7'b1111000,   // 7
      7'b0000000,   // 8
      7'b0010000    // 9
   };

   // log10(2) ~ 3/10, plus one digit of headroom: 8->3, 10->4, 16->5
   function automatic int bcd_width(input int dw);
      return (dw * 3) / 10 + 1;
   endfunction

endpackage

// File: rtl/bcd_seg_display_seg7_encode.sv
// ---------------------------------------------------------------------------
// seg7_encode
// Combinational BCD nibble to active-low seven-segment code.
// Ports:
//   nibble  in  4  BCD digit (values above 9 show blank)
//   blank   in  1  force all segments off
//   dash    in  1  force "-" (takes priority over blank)
//   seg     out 7  active-low {g,f,e,d,c,b,a}
// ---------------------------------------------------------------------------
module seg7_encode
   import bcd_seg_display_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       blank,
   input  logic       dash,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      if (dash)
         seg = SEG_DASH;
      else if (blank)
         seg = SEG_BLANK;
      else if (nibble <= 4'd9)
         seg = SEG_DIGIT[nibble];
   end

endmodule

// File: rtl/bcd_seg_display.sv
// ---------------------------------------------------------------------------
// bcd_seg_display
// Multi-channel binary to seven-segment driver. Each channel is converted
// sequentially with shift-add-3 (double dabble), encoded into a shadow
// buffer, and the whole buffer is copied to the outputs in one cycle so the
// display never shows a partially converted frame.
// Ports:
//   clock     in  1              rising-edge clock
//   reset     in  1              synchronous, active-high
//   start     in  1              convert request, ignored unless idle
//   data      in  CH*DATA_W      channel c at data[c*DATA_W +: DATA_W]
//   blank_lz  in  1              leading-zero blanking, sampled with start
//   busy      out 1              conversion in progress
//   done      out 1              one-cycle pulse when seven is updated
//   seven     out CH*DIGITS*7    channel c at seven[c*DIGITS*7 +: DIGITS*7],
//                                digit 0 (ones) lowest, active-low
// ---------------------------------------------------------------------------
module bcd_seg_display
   import bcd_seg_display_pkg::*;
#(
   parameter int CH     = 3,
   parameter int DATA_W = 8,
   parameter int DIGITS = 3
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     start,
   input  logic [CH*DATA_W-1:0]     data,
   input  logic                     blank_lz,
   output logic                     busy,
   output logic                     done,
   output logic [CH*DIGITS*7-1:0]   seven
);

   localparam int BW  = bcd_width(DATA_W);
   localparam int CIW = (CH > 1) ? $clog2(CH) : 1;
   localparam int CW  = $clog2(DATA_W);

   state_t                    state;
   logic [CH*DATA_W-1:0]      snap;
   logic                      lz;
   logic [CIW-1:0]            ch_idx;
   logic [DATA_W-1:0]         shreg;
   logic [4*BW-1:0]           bcd;
   logic [4*BW-1:0]           bcd_adj;
   logic [4*BW+DATA_W-1:0]    shift_nxt;
   logic [CW-1:0]             cnt;
   logic [CH*DIGITS*7-1:0]    shadow;

   logic [4*DIGITS-1:0]       digs;
   logic [DIGITS-1:0]         blk;
   logic                      ovf;
   logic                      zero_above;
   logic [DIGITS*7-1:0]       enc;

   // Add-3 correction on every nibble >= 5, then one left shift of the
   // combined {bcd, shreg} register.
   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < BW; i++) begin
         if (bcd[4*i +: 4] >= 4'd5)
            bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
      shift_nxt = {bcd_adj, shreg} << 1;
   end

   // Displayed digits: BCD digits beyond BW are padded with zero.
   for (genvar i = 0; i < DIGITS; i++) begin : g_dig
      if (i < BW) begin : g_bcd
         assign digs[4*i +: 4] = bcd[4*i +: 4];
      end else begin : g_pad
         assign digs[4*i +: 4] = 4'd0;
      end

      seg7_encode u_enc (
         .nibble (digs[4*i +: 4]),
         .blank  (blk[i]),
         .dash   (ovf),
         .seg    (enc[7*i +: 7])
      );
   end

   // Overflow: a nonzero BCD digit that has no display position.
   if (BW > DIGITS) begin : g_ovf
      assign ovf = |bcd[4*BW-1:4*DIGITS];
   end else begin : g_no_ovf
      assign ovf = 1'b0;
   end

   // A digit is blanked when it and every digit above it are zero. Digit 0
   // is never blanked, so a zero value still shows a single "0".
   always_comb begin
      zero_above = 1'b1;
      blk        = '0;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         zero_above = zero_above & (digs[4*i +: 4] == 4'd0);
         blk[i]     = lz & zero_above;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state  <= S_IDLE;
         busy   <= 1'b0;
         done   <= 1'b0;
         seven  <= '1;
         snap   <= '0;
         lz     <= 1'b0;
         ch_idx <= '0;
         shreg  <= '0;
         bcd    <= '0;
         cnt    <= '0;
         shadow <= '1;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  snap   <= data;
                  lz     <= blank_lz;
                  ch_idx <= '0;
                  busy   <= 1'b1;
                  state  <= S_LOAD;
               end
            end
            S_LOAD: begin
               shreg <= snap[ch_idx*DATA_W +: DATA_W];
               bcd   <= '0;
               cnt   <= CW'(DATA_W - 1);
               state <= S_SHIFT;
            end
            S_SHIFT: begin
               {bcd, shreg} <= shift_nxt;
               cnt          <= cnt - 1'b1;
               if (cnt == '0)
                  state <= S_STORE;
            end
            S_STORE: begin
               shadow[ch_idx*DIGITS*7 +: DIGITS*7] <= enc;
               if (ch_idx == CIW'(CH - 1)) begin
                  state <= S_DONE;
               end else begin
                  ch_idx <= ch_idx + 1'b1;
                  state  <= S_LOAD;
               end
            end
            S_DONE: begin
               // start is not looked at here; it is accepted from IDLE only
               seven <= shadow;
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_seg_display.sv
module tb_bcd_seg_display;

   localparam logic [6:0] S0 = 7'b1000000;
   localparam logic [6:0] S1 = 7'b1111001;
   localparam logic [6:0] S2 = 7'b0100100;
   localparam logic [6:0] S3 = 7'b0110000;
   localparam logic [6:0] S4 = 7'b0011001;
   localparam logic [6:0] S5 = 7'b0010010;
   localparam logic [6:0] S6 = 7'b0000010;
   localparam logic [6:0] S7 = 7'b1111000;
   localparam logic [6:0] S8 = 7'b0000000;
   localparam logic [6:0] S9 = 7'b0010000;
   localparam logic [6:0] BL = 7'b1111111;
   localparam logic [6:0] DS = 7'b0111111;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic reset = 1'b1;

   // default configuration: CH=3, DATA_W=8, DIGITS=3
   logic        a_start = 1'b0, a_lz = 1'b0, a_busy, a_done;
   logic [23:0] a_data = '0;
   logic [62:0] a_seven;

   // CH=2, DATA_W=8, DIGITS=2
   logic        b_start = 1'b0, b_lz = 1'b0, b_busy, b_done;
   logic [15:0] b_data = '0;
   logic [27:0] b_seven;

   // CH=1, DATA_W=16, DIGITS=5
   logic        c_start = 1'b0, c_lz = 1'b0, c_busy, c_done;
   logic [15:0] c_data = '0;
   logic [34:0] c_seven;

   int total = 0;
   int bad   = 0;

   bcd_seg_display #(.CH(3), .DATA_W(8), .DIGITS(3)) dut_a (
      .clock(clock), .reset(reset), .start(a_start), .data(a_data),
      .blank_lz(a_lz), .busy(a_busy), .done(a_done), .seven(a_seven));

   bcd_seg_display #(.CH(2), .DATA_W(8), .DIGITS(2)) dut_b (
      .clock(clock), .reset(reset), .start(b_start), .data(b_data),
      .blank_lz(b_lz), .busy(b_busy), .done(b_done), .seven(b_seven));

   bcd_seg_display #(.CH(1), .DATA_W(16), .DIGITS(5)) dut_c (
      .clock(clock), .reset(reset), .start(c_start), .data(c_data),
      .blank_lz(c_lz), .busy(c_busy), .done(c_done), .seven(c_seven));

   // Stimulus drivers: pulse start for one edge, return the number of edges
   // after the start edge at which done was seen (-1 on timeout).
   task automatic run_a(input logic [23:0] d, input logic lz, output int lat);
      @(negedge clock); a_data = d; a_lz = lz; a_start = 1'b1;
      @(negedge clock); a_start = 1'b0; lat = -1;
      for (int k = 1; k <= 100; k++) begin
         @(negedge clock);
         if (a_done === 1'b1) begin lat = k; break; end
      end
   endtask

   task automatic run_b(input logic [15:0] d, input logic lz, output int lat);
      @(negedge clock); b_data = d; b_lz = lz; b_start = 1'b1;
      @(negedge clock); b_start = 1'b0; lat = -1;
      for (int k = 1; k <= 100; k++) begin
         @(negedge clock);
         if (b_done === 1'b1) begin lat = k; break; end
      end
   endtask

   task automatic run_c(input logic [15:0] d, input logic lz, output int lat);
      @(negedge clock); c_data = d; c_lz = lz; c_start = 1'b1;
      @(negedge clock); c_start = 1'b0; lat = -1;
      for (int k = 1; k <= 100; k++) begin
         @(negedge clock);
         if (c_done === 1'b1) begin lat = k; break; end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      total++; if (a_seven !== '1) begin bad++; $display("FAIL reset_seven_a got=%h want=all ones", a_seven); end
      total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL reset_busy_a got=%b want=0", a_busy); end
      total++; if (a_done !== 1'b0) begin bad++; $display("FAIL reset_done_a got=%b want=0", a_done); end
      total++; if (b_seven !== '1) begin bad++; $display("FAIL reset_seven_b got=%h want=all ones", b_seven); end
      total++; if (c_seven !== '1) begin bad++; $display("FAIL reset_seven_c got=%h want=all ones", c_seven); end
   endtask

   task automatic test_convert();
      int lat;
      run_a({8'd255, 8'd7, 8'd0}, 1'b0, lat);
      total++; if (lat != 31) begin bad++; $display("FAIL convert_latency got=%0d want=31", lat); end
      total++; if (a_seven !== {S2, S5, S5, S0, S0, S7, S0, S0, S0}) begin
         bad++; $display("FAIL convert_seven got=%h want=%h", a_seven, {S2, S5, S5, S0, S0, S7, S0, S0, S0}); end
      total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL convert_busy_after_done got=%b want=0", a_busy); end
      @(negedge clock);
      total++; if (a_done !== 1'b0) begin bad++; $display("FAIL convert_done_pulse got=%b want=0", a_done); end
   endtask

   task automatic test_blank_lz();
      int lat;
      run_a({8'd255, 8'd7, 8'd0}, 1'b1, lat);
      total++; if (lat != 31) begin bad++; $display("FAIL blank_latency got=%0d want=31", lat); end
      total++; if (a_seven !== {S2, S5, S5, BL, BL, S7, BL, BL, S0}) begin
         bad++; $display("FAIL blank_seven got=%h want=%h", a_seven, {S2, S5, S5, BL, BL, S7, BL, BL, S0}); end
   endtask

   task automatic test_overflow();
      int lat;
      run_b({8'd99, 8'd100}, 1'b0, lat);
      total++; if (lat != 21) begin bad++; $display("FAIL ovf_latency got=%0d want=21", lat); end
      total++; if (b_seven !== {S9, S9, DS, DS}) begin
         bad++; $display("FAIL ovf_seven got=%h want=%h", b_seven, {S9, S9, DS, DS}); end
      // overflow wins over blanking; 5 is blanked to a single digit
      run_b({8'd5, 8'd250}, 1'b1, lat);
      total++; if (lat != 21) begin bad++; $display("FAIL ovf_blank_latency got=%0d want=21", lat); end
      total++; if (b_seven !== {BL, S5, DS, DS}) begin
         bad++; $display("FAIL ovf_blank_seven got=%h want=%h", b_seven, {BL, S5, DS, DS}); end
   endtask

   task automatic test_wide();
      int lat;
      run_c(16'd65535, 1'b0, lat);
      total++; if (lat != 19) begin bad++; $display("FAIL wide_latency got=%0d want=19", lat); end
      total++; if (c_seven !== {S6, S5, S5, S3, S5}) begin
         bad++; $display("FAIL wide_seven got=%h want=%h", c_seven, {S6, S5, S5, S3, S5}); end
      run_c(16'd0, 1'b1, lat);
      total++; if (lat != 19) begin bad++; $display("FAIL wide_zero_latency got=%0d want=19", lat); end
      total++; if (c_seven !== {BL, BL, BL, BL, S0}) begin
         bad++; $display("FAIL wide_zero_seven got=%h want=%h", c_seven, {BL, BL, BL, BL, S0}); end
   endtask

   task automatic test_back_to_back();
      int nd, dc;
      @(negedge clock); a_data = {8'd123, 8'd45, 8'd6}; a_lz = 1'b0; a_start = 1'b1;
      @(negedge clock); a_start = 1'b0; nd = 0; dc = -1;
      for (int k = 1; k <= 45; k++) begin
         a_start = (k == 5 || k == 31);
         if (k == 10) begin a_data = '1; a_lz = 1'b1; end
         @(negedge clock);
         if (a_done === 1'b1) begin nd++; dc = k; end
      end
      a_start = 1'b0;
      total++; if (nd != 1) begin bad++; $display("FAIL b2b_done_count got=%0d want=1", nd); end
      total++; if (dc != 31) begin bad++; $display("FAIL b2b_done_cycle got=%0d want=31", dc); end
      total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL b2b_busy got=%b want=0", a_busy); end
      total++; if (a_seven !== {S1, S2, S3, S0, S4, S5, S0, S0, S6}) begin
         bad++; $display("FAIL b2b_seven got=%h want=%h", a_seven, {S1, S2, S3, S0, S4, S5, S0, S0, S6}); end
   endtask

   task automatic test_reset_mid();
      int nd, lat;
      @(negedge clock); a_data = {8'd1, 8'd2, 8'd3}; a_lz = 1'b0; a_start = 1'b1;
      @(negedge clock); a_start = 1'b0;
      for (int k = 1; k <= 15; k++) begin
         if (k == 15) reset = 1'b1;
         @(negedge clock);
      end
      total++; if (a_seven !== '1) begin bad++; $display("FAIL midrst_seven got=%h want=all ones", a_seven); end
      total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", a_busy); end
      total++; if (a_done !== 1'b0) begin bad++; $display("FAIL midrst_done got=%b want=0", a_done); end
      reset = 1'b0;
      nd = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clock);
         if (a_done === 1'b1) nd++;
      end
      total++; if (nd != 0) begin bad++; $display("FAIL midrst_no_done got=%0d want=0", nd); end
      run_a({8'd200, 8'd38, 8'd9}, 1'b1, lat);
      total++; if (lat != 31) begin bad++; $display("FAIL midrst_restart_latency got=%0d want=31", lat); end
      total++; if (a_seven !== {S2, S0, S0, BL, S3, S8, BL, BL, S9}) begin
         bad++; $display("FAIL midrst_restart_seven got=%h want=%h", a_seven, {S2, S0, S0, BL, S3, S8, BL, BL, S9}); end
   endtask

   initial begin
      test_reset();
      test_convert();
      test_blank_lz();
      test_overflow();
      test_wide();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
